z80_bus_bridge: RTL
===================

// Module: z80_bus_bridge
// PURPOSE
//  Sits directly below the tv80s core. Turns raw Z80 bus strobes (mreq_n/iorq_n/rd_n/wr_n/m1_n/rfsh_n)
//  into a single-request req/ack transaction toward a synchronous 64 KiB memory. IO cycles are mapped
//  into page {IO_PAGE, A[7:0]}. The bridge drives cpu_wait_n to stretch cycles until data is valid.
//  Replaces the bench's negedge behavioural memory glue with a clk-posedge, synthesizable stage.
// PARAMETERS
//  IO_PAGE    8'h10  high address byte used for IO cycles (mem_addr = {IO_PAGE, cpu_a[7:0]})
//  MEM_WAIT   0      extra wait cycles added after mem_ack on memory cycles (0..15)
//  IO_WAIT    1      extra wait cycles added after mem_ack on IO cycles (0..15); models the Z80 auto-TW
//  INTA_DATA  8'hFF  byte returned on interrupt-acknowledge cycles (RST 38h)
// PORTS
//  clk         in   1   single clock; all state changes on posedge
//  reset       in   1   asynchronous, active-high
//  cpu_a       in   16  CPU address
//  cpu_dout    in   8   CPU write data
//  cpu_mreq_n  in   1   memory request
//  cpu_iorq_n  in   1   IO request
//  cpu_rd_n    in   1   read strobe
//  cpu_wr_n    in   1   write strobe
//  cpu_m1_n    in   1   opcode fetch / INTA qualifier
//  cpu_rfsh_n  in   1   refresh qualifier
//  cpu_di      out  8   read data to CPU (registered)
//  cpu_wait_n  out  1   0 = stretch current bus cycle
//  mem_req     out  1   request; held high until mem_ack sampled high
//  mem_we      out  1   1 = write, valid while mem_req
//  mem_addr    out  16  address, valid while mem_req
//  mem_wdata   out  8   write data, valid while mem_req
//  mem_rdata   in   8   read data, valid in the cycle mem_ack=1
//  mem_ack     in   1   completes the request (one-cycle pulse)
//  cyc_io      out  1   1 while the active transaction is an IO cycle
// BEHAVIOUR
//  Reset values: cpu_di=8'h00, cpu_wait_n=1, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cyc_io=0, state=IDLE.
//  Qualified strobe: (!mreq_n | !iorq_n) & (!rd_n | !wr_n) & rfsh_n. Refresh (rfsh_n=0) never requests.
//  INTA (!m1_n & !iorq_n): no mem_req; cpu_di<=INTA_DATA next posedge, go to DONE, wait_n stays 1.
//  mreq_n and iorq_n low together without m1_n low: IO wins.
//  FSM IDLE->REQ->WAITST->DONE->IDLE:
//   IDLE: on qualified strobe latch addr/we/wdata/cyc_io, mem_req<=1, go to REQ.
//     cpu_wait_n is combinational: 0 when IDLE and a qualified strobe is present.
//   REQ: cpu_wait_n=0. On mem_ack: mem_req<=0, capture mem_rdata into cpu_di (reads only),
//     load the wait counter with MEM_WAIT/IO_WAIT. If the count is 0 go to DONE, else go to WAITST.
//   WAITST: cpu_wait_n=0; decrement each cycle; go to DONE when the counter reaches 1.
//   DONE: cpu_wait_n=1, cpu_di held. Return to IDLE when no qualified strobe is present
//     (both mreq_n and iorq_n high). Exactly one downstream request per CPU bus cycle,
//     however many cycles wr_n stays low.
//  Latency: with mem_ack 1 cycle after mem_req and MEM_WAIT=0, cpu_wait_n is low for exactly 2 clocks.
//  Abort: strobes removed while in REQ/WAITST -> mem_req held until ack (ack discarded), then IDLE;
//    cpu_di unchanged.
//  Reset mid-transaction: all outputs return to reset values immediately; a pending ack is ignored.
//  Address wrap: none needed; mem_addr is a 16-bit pass-through; IO uses only cpu_a[7:0].
//  mem_ack while mem_req=0: ignored.
// STRUCTURE
//  Package z80_bus_pkg: state enum {IDLE,REQ,WAITST,DONE}, WAITCNT_W=4, default IO_PAGE,
//    INTA_DATA constants.
//  Sub-module z80_wait_counter: loadable 4-bit down-counter with a zero flag; used only by WAITST.
// TESTING
//  1 Mem read, MEM_WAIT=0, ack 1 clk after req: A=0000, mem_rdata=EC -> cpu_di=EC,
//    cpu_wait_n low 2 clks, one mem_req.
//  2 IO write OUT (34h),A with A=5A, IO_WAIT=1 -> mem_addr=1034, mem_we=1, mem_wdata=5A,
//    cyc_io=1, wait_n low 3 clks.
//  3 INTA cycle (m1_n=0, iorq_n=0) -> cpu_di=FF, mem_req never asserted; refresh cycles
//    -> zero mem_req pulses.
//  4 Write strobe held 4 clks -> exactly one mem_req/mem_we pulse; reset asserted while in REQ
//    -> mem_req=0, wait_n=1 the same cycle.
//  5 Full tv80s run: mem 0000..0002 = EC 61 9C, F=0E, SP=5698 (CALL PE,9C61) -> mem[5696]=03,
//    mem[5697]=00, PC=9C61, SP=5696, R=01.
//  6 Random ack delay 0..7 clks with MEM_WAIT=3 -> cpu_di matches the memory model on every read;
//    no duplicate or lost write.

Source files
------------

// File: rtl/z80_bus_pkg.sv
// z80_bus_pkg
//   Shared types and constants for the Z80 bus bridge: the bridge FSM state
//   encoding, the wait-counter width, and default values for the IO page and
//   the interrupt-acknowledge data byte.
package z80_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAITST,
    DONE
  } state_t;

  localparam int         WAITCNT_W     = 4;
  localparam logic [7:0] IO_PAGE_DEF   = 8'h10;
  localparam logic [7:0] INTA_DATA_DEF = 8'hFF;

  // IO cycles only decode the low address byte; the high byte selects a page.
  function automatic logic [15:0] io_addr(input logic [7:0] page, input logic [7:0] port);
    return {page, port};
  endfunction

endpackage

// File: rtl/z80_wait_counter.sv
// z80_wait_counter
//   Loadable down-counter used to insert extra wait states after a memory
//   acknowledge. Load has priority over decrement; decrement stops at zero.
// Ports
//   clk       in   clock
//   reset     in   asynchronous, active-high
//   load      in   load load_val this cycle
//   load_val  in   value to load
//   dec       in   decrement this cycle (ignored while zero)
//   count     out  current count
//   zero      out  count == 0
module z80_wait_counter
  import z80_bus_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [WAITCNT_W-1:0] load_val,
  input  logic                 dec,
  output logic [WAITCNT_W-1:0] count,
  output logic                 zero
);

  logic [WAITCNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/z80_bus_bridge.sv
// z80_bus_bridge
//   Converts raw Z80 bus strobes into a single req/ack transaction toward a
//   synchronous 64 KiB memory, stretching the CPU cycle with cpu_wait_n until
//   read data is valid. IO cycles map to page {IO_PAGE, cpu_a[7:0]}; interrupt
//   acknowledge returns INTA_DATA without touching memory.
// Ports
//   clk, reset                    clock, asynchronous active-high reset
//   cpu_a, cpu_dout               CPU address / write data
//   cpu_mreq_n, cpu_iorq_n        memory / IO request strobes
//   cpu_rd_n, cpu_wr_n            read / write strobes
//   cpu_m1_n, cpu_rfsh_n          fetch/INTA qualifier, refresh qualifier
//   cpu_di                        registered read data to the CPU
//   cpu_wait_n                    0 stretches the current bus cycle
//   mem_req, mem_we, mem_addr,
//   mem_wdata                     request toward memory, held until mem_ack
//   mem_rdata, mem_ack            memory response (ack is a one-cycle pulse)
//   cyc_io                        1 while the active transaction is IO
module z80_bus_bridge
  import z80_bus_pkg::*;
#(
  parameter logic [7:0] IO_PAGE   = IO_PAGE_DEF,
  parameter int         MEM_WAIT  = 0,
  parameter int         IO_WAIT   = 1,
  parameter logic [7:0] INTA_DATA = INTA_DATA_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_mreq_n,
  input  logic        cpu_iorq_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  input  logic        cpu_m1_n,
  input  logic        cpu_rfsh_n,
  output logic [7:0]  cpu_di,
  output logic        cpu_wait_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        cyc_io
);

  localparam logic [WAITCNT_W-1:0] MEM_WAIT_C = WAITCNT_W'(MEM_WAIT);
  localparam logic [WAITCNT_W-1:0] IO_WAIT_C  = WAITCNT_W'(IO_WAIT);

  state_t state_d, state_q;
  logic [7:0]  di_d, di_q;
  logic        req_d, req_q;
  logic        we_d, we_q;
  logic [15:0] addr_d, addr_q;
  logic [7:0]  wdata_d, wdata_q;
  logic        io_d, io_q;
  logic        abort_d, abort_q;

  logic                 cnt_load, cnt_dec, wait_zero;
  logic [WAITCNT_W-1:0] wait_sel, wait_cnt;

  // Refresh cycles also pull mreq_n low; rfsh_n keeps them from qualifying.
  logic qual, inta, bus_idle;
  assign qual     = (!cpu_mreq_n || !cpu_iorq_n) && (!cpu_rd_n || !cpu_wr_n) && cpu_rfsh_n;
  assign inta     = !cpu_m1_n && !cpu_iorq_n && cpu_rfsh_n;
  assign bus_idle = cpu_mreq_n && cpu_iorq_n;
  assign wait_sel = io_q ? IO_WAIT_C : MEM_WAIT_C;

  z80_wait_counter u_wait_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (wait_sel),
    .dec      (cnt_dec),
    .count    (wait_cnt),
    .zero     (wait_zero)
  );

  always_comb begin
    state_d  = state_q;
    di_d     = di_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    io_d     = io_q;
    abort_d  = abort_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    case (state_q)
      IDLE: begin
        if (inta) begin
          di_d    = INTA_DATA;
          state_d = DONE;
        end else if (qual) begin
          // IO wins when mreq_n and iorq_n are both low.
          req_d   = 1'b1;
          we_d    = !cpu_wr_n;
          io_d    = !cpu_iorq_n;
          addr_d  = !cpu_iorq_n ? io_addr(IO_PAGE, cpu_a[7:0]) : cpu_a;
          wdata_d = cpu_dout;
          abort_d = 1'b0;
          state_d = REQ;
        end
      end

      REQ: begin
        // Once the CPU walks away the request still completes, but its ack is discarded.
        abort_d = abort_q || !qual;
        if (mem_ack) begin
          req_d = 1'b0;
          if (abort_q || !qual) begin
            abort_d = 1'b0;
            io_d    = 1'b0;
            state_d = IDLE;
          end else begin
            if (!we_q) begin
              di_d = mem_rdata;
            end
            cnt_load = 1'b1;
            state_d  = (wait_sel == '0) ? DONE : WAITST;
          end
        end
      end

      WAITST: begin
        if (!qual) begin
          io_d    = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_dec = 1'b1;
          if ((wait_cnt == WAITCNT_W'(1)) || wait_zero) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        // Hold here for the rest of the CPU cycle so a long wr_n cannot re-request.
        if (bus_idle) begin
          io_d    = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      di_q    <= 8'h00;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
      io_q    <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      di_q    <= di_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      io_q    <= io_d;
      abort_q <= abort_d;
    end
  end

  // Stretch immediately on a fresh strobe in IDLE; reset forces the released level.
  always_comb begin
    cpu_wait_n = 1'b1;
    if (!reset) begin
      case (state_q)
        IDLE:    cpu_wait_n = !(qual && !inta);
        REQ:     cpu_wait_n = 1'b0;
        WAITST:  cpu_wait_n = 1'b0;
        default: cpu_wait_n = 1'b1;
      endcase
    end
  end

  assign cpu_di    = di_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cyc_io    = io_q;

endmodule
